// File: rtl/tmds_ddr_word_aligner_if.sv
// Bit-pair input and aligned-word output bundle of the TMDS word aligner.
// The bench drives through master; the aligner sits on slave.
interface tmds_ddr_word_aligner_if;
   logic [1:0] din;
   logic       resync;
   logic [9:0] word_out;
   logic       word_valid;
   logic       locked;
   logic [3:0] bit_offset;
   logic       token_hit;

   modport master (
      output din, resync,
      input  word_out, word_valid, locked, bit_offset, token_hit
   );

   modport slave (
      input  din, resync,
      output word_out, word_valid, locked, bit_offset, token_hit
   );
endinterface

// File: rtl/tmds_ddr_word_aligner.sv
// Builds 10-bit TMDS words from IDDR bit pairs and finds word alignment by
// slipping one bit at a time until HDMI control tokens appear consistently.
module tmds_ddr_word_aligner #(
   parameter int unsigned SEARCH_WORDS = 16,
   parameter int unsigned LOCK_TOKENS  = 8,
   parameter int unsigned LOSS_WORDS   = 2048
) (
   input logic                    clk,
   input logic                    reset,
   tmds_ddr_word_aligner_if.slave bus
);
   localparam int unsigned MISS_W = $clog2(SEARCH_WORDS + 1);
   localparam int unsigned HIT_W  = $clog2(LOCK_TOKENS + 1);
   localparam int unsigned LOSS_W = $clog2(LOSS_WORDS + 1);
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(SEARCH_WORDS - 1);
   localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_TOKENS - 1);
   localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_WORDS - 1);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t            r_state;
   logic [19:0]       r_sr;
   logic [2:0]        r_phase;
   logic [3:0]        r_offset;
   logic [MISS_W-1:0] r_miss;
   logic [HIT_W-1:0]  r_hit;
   logic [LOSS_W-1:0] r_loss;
   logic [9:0]        r_word;
   logic              r_valid;
   logic              r_token;
   logic              r_locked;

   logic [19:0] w_sr_nx;
   logic [9:0]  w_word;
   logic        w_token;
   logic        w_eval;
   logic [3:0]  w_offset_inc;

   // Oldest bit sits at index 0, so an offset selects a window from the past.
   assign w_sr_nx      = {bus.din[1], bus.din[0], r_sr[19:2]};
   assign w_word       = w_sr_nx[r_offset +: 10];
   assign w_token      = (w_word == 10'h354) || (w_word == 10'h0AB) ||
                         (w_word == 10'h154) || (w_word == 10'h2AB);
   assign w_eval       = (r_phase == 3'd4);
   assign w_offset_inc = (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sr    <= '0;
         r_phase <= '0;
         r_word  <= '0;
         r_valid <= 1'b0;
         r_token <= 1'b0;
      end else begin
         r_sr    <= w_sr_nx;
         r_valid <= w_eval;
         if (w_eval) begin
            r_phase <= '0;
            r_word  <= w_word;
            r_token <= w_token;
         end else begin
            r_phase <= r_phase + 3'd1;
         end
      end
   end

   // resync overrides the per-word evaluation even when both land on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= SEARCH;
         r_offset <= '0;
         r_miss   <= '0;
         r_hit    <= '0;
         r_loss   <= '0;
         r_locked <= 1'b0;
      end else if (bus.resync) begin
         r_state  <= SEARCH;
         r_offset <= w_offset_inc;
         r_miss   <= '0;
         r_hit    <= '0;
         r_loss   <= '0;
         r_locked <= 1'b0;
      end else if (w_eval) begin
         case (r_state)
            SEARCH: begin
               if (w_token) begin
                  r_state <= VERIFY;
                  r_hit   <= HIT_W'(1);
                  r_miss  <= '0;
               end else if (r_miss >= MISS_LAST) begin
                  r_offset <= w_offset_inc;
                  r_miss   <= '0;
               end else begin
                  r_miss <= r_miss + 1'b1;
               end
            end
            VERIFY: begin
               if (!w_token) begin
                  r_state <= SEARCH;
                  r_hit   <= '0;
                  r_miss  <= '0;
               end else if (r_hit >= HIT_LAST) begin
                  r_state  <= LOCKED;
                  r_hit    <= '0;
                  r_loss   <= '0;
                  r_locked <= 1'b1;
               end else begin
                  r_hit <= r_hit + 1'b1;
               end
            end
            LOCKED: begin
               if (w_token) begin
                  r_loss <= '0;
               end else if (r_loss >= LOSS_LAST) begin
                  r_state  <= SEARCH;
                  r_loss   <= '0;
                  r_miss   <= '0;
                  r_hit    <= '0;
                  r_locked <= 1'b0;
               end else begin
                  r_loss <= r_loss + 1'b1;
               end
            end
            default: begin
               r_state  <= SEARCH;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign bus.word_out   = r_word;
   assign bus.word_valid = r_valid;
   assign bus.token_hit  = r_token;
   assign bus.locked     = r_locked;
   assign bus.bit_offset = r_offset;
endmodule

// File: tb/tb_tmds_ddr_word_aligner.sv
// Scoreboard bench for the TMDS word aligner: stimulus pushes expected words,
// a negedge monitor pops and compares on every word_valid strobe.
module tb_tmds_ddr_word_aligner;
   localparam logic [9:0] TOK = 10'h354;
   localparam logic [9:0] NT  = 10'h1F0;
   localparam int SW = 16;
   localparam int LT = 8;
   localparam int LW = 2048;

   typedef struct {
      logic [9:0] w;
      logic       tok;
      logic       lck;
      logic [3:0] off;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   tmds_ddr_word_aligner_if bus();

   tmds_ddr_word_aligner #(
      .SEARCH_WORDS (SW),
      .LOCK_TOKENS  (LT),
      .LOSS_WORDS   (LW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   exp_t expq[$];
   bit   txq[$];
   bit   stream[$];
   int   passed = 0;
   int   total = 0;
   int   pairs = 0;
   int   strobe_no = 0;
   int   lock_strobe = 0;
   int   m_state = 0, m_off = 0, m_miss = 0, m_hit = 0, m_loss = 0;

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, req);
   endtask

   // Reference: the word shown at a strobe is the 10-bit window starting
   // 20 bits before the newest captured bit, shifted by the offset.
   task automatic m_strobe(input bit rs);
      logic [9:0] win;
      bit tok;
      int n;
      int idx;
      exp_t e;
      n = stream.size();
      for (int j = 0; j < 10; j++) begin
         idx = n - 20 + m_off + j;
         win[j] = (idx >= 0) ? stream[idx] : 1'b0;
      end
      tok = (win == 10'h354) || (win == 10'h0AB) || (win == 10'h154) || (win == 10'h2AB);
      if (rs) begin
         m_state = 0; m_off = (m_off + 1) % 10; m_miss = 0; m_hit = 0; m_loss = 0;
      end else if (m_state == 0) begin
         if (tok) begin m_state = 1; m_hit = 1; m_miss = 0; end
         else begin
            m_miss++;
            if (m_miss == SW) begin m_miss = 0; m_off = (m_off + 1) % 10; end
         end
      end else if (m_state == 1) begin
         if (tok) begin
            m_hit++;
            if (m_hit == LT) begin m_state = 2; m_loss = 0; end
         end else begin m_state = 0; m_hit = 0; end
      end else begin
         if (tok) m_loss = 0;
         else begin
            m_loss++;
            if (m_loss == LW) begin m_state = 0; m_loss = 0; m_hit = 0; m_miss = 0; end
         end
      end
      e.w = win; e.tok = tok; e.lck = (m_state == 2); e.off = 4'(m_off);
      expq.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.word_valid) begin
         strobe_no++;
         if (expq.size() == 0) chk("unexpected_strobe", 1, 0);
         else begin
            e = expq.pop_front();
            chk("word_out", bus.word_out, e.w);
            chk("token_hit", bus.token_hit, e.tok);
            chk("locked", bus.locked, e.lck);
            chk("bit_offset", bus.bit_offset, e.off);
         end
         if (bus.locked && lock_strobe == 0) lock_strobe = strobe_no;
      end
   end

   task automatic push_word(input logic [9:0] w);
      for (int j = 0; j < 10; j++) txq.push_back(w[j]);
   endtask

   task automatic push_zeros(input int n);
      for (int j = 0; j < n; j++) txq.push_back(1'b0);
   endtask

   task automatic tick(input bit rs);
      bit b0, b1;
      b0 = (txq.size() > 0) ? txq.pop_front() : 1'b0;
      b1 = (txq.size() > 0) ? txq.pop_front() : 1'b0;
      bus.din = {b1, b0};
      bus.resync = rs;
      @(posedge clk); #1;
      stream.push_back(b0);
      stream.push_back(b1);
      pairs++;
      if (pairs % 5 == 0) m_strobe(rs);
      chk("strobe_timing", bus.word_valid, (pairs % 5 == 0) ? 1 : 0);
      @(negedge clk); #1;
      bus.resync = 1'b0;
   endtask

   task automatic run(input int nwords, input bit rs);
      for (int w = 0; w < nwords; w++)
         for (int p = 0; p < 5; p++) tick(rs && (p == 4));
   endtask

   task automatic do_reset();
      chk("exp_drained_before_reset", expq.size(), 0);
      reset = 1'b1;
      bus.din = 2'b00;
      bus.resync = 1'b0;
      @(posedge clk); #1;
      chk("rst_word_out", bus.word_out, 0);
      chk("rst_word_valid", bus.word_valid, 0);
      chk("rst_locked", bus.locked, 0);
      chk("rst_bit_offset", bus.bit_offset, 0);
      chk("rst_token_hit", bus.token_hit, 0);
      @(posedge clk);
      @(negedge clk); #1;
      txq.delete(); stream.delete(); expq.delete();
      pairs = 0; strobe_no = 0; lock_strobe = 0;
      m_state = 0; m_off = 0; m_miss = 0; m_hit = 0; m_loss = 0;
      reset = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.din = 2'b00;
      bus.resync = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      do_reset();

      // Aligned stream, then the loss-of-lock sequence at offset 0.
      // Strobe 1 holds reset history, so tokens are seen from strobe 2.
      repeat (11) push_word(TOK);
      repeat (2047) push_word(NT);
      push_word(TOK);
      repeat (2048) push_word(NT);
      push_word(TOK);
      run(12, 1'b0);
      chk("t1_lock_strobe", lock_strobe, 9);
      chk("t1_locked", bus.locked, 1);
      chk("t1_offset", bus.bit_offset, 0);
      run(2048, 1'b0);
      chk("t4_locked_after_token", bus.locked, 1);
      run(2047, 1'b0);
      chk("t4_locked_2047_miss", bus.locked, 1);
      run(1, 1'b0);
      chk("t4_dropped", bus.locked, 0);
      chk("t4_offset_kept", bus.bit_offset, 0);

      // Skew of 3 bits: offsets 0,1,2 exhausted, lock at offset 3.
      do_reset();
      push_zeros(3);
      repeat (60) push_word(TOK);
      run(58, 1'b0);
      chk("t2_lock_strobe", lock_strobe, 56);
      chk("t2_offset", bus.bit_offset, 3);
      chk("t2_locked", bus.locked, 1);

      // Reset on the phase-2 edge while locked.
      tick(1'b0);
      tick(1'b0);
      do_reset();

      // Five tokens in VERIFY, then a non-token word.
      repeat (5) push_word(TOK);
      push_word(NT);
      repeat (10) push_word(TOK);
      run(12, 1'b0);
      chk("t5_never_locked", lock_strobe, 0);
      chk("t5_locked", bus.locked, 0);
      chk("t5_offset", bus.bit_offset, 0);

      // Nine resyncs to offset 9, lock on a 9-bit skew, one more resync.
      do_reset();
      push_zeros(9);
      repeat (30) push_word(TOK);
      run(9, 1'b1);
      chk("t3_offset_after_resync", bus.bit_offset, 9);
      chk("t3_not_locked_yet", bus.locked, 0);
      run(8, 1'b0);
      chk("t3_lock_strobe", lock_strobe, 17);
      chk("t3_offset", bus.bit_offset, 9);
      run(1, 1'b1);
      chk("t3_resync_offset", bus.bit_offset, 0);
      chk("t3_resync_unlock", bus.locked, 0);

      chk("exp_drained", expq.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
